// File: rtl/mem_if.sv
// CPU-side memory access controller: latches one request, drives the memory
// strobes for WAIT_CYCLES cycles, then reports completion or an address fault.
module mem_if #(
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH_BITS  = 9
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t                state;
  state_t                state_d;
  logic [3:0]            cnt;
  logic [3:0]            cnt_d;
  logic [DEPTH_BITS-1:0] mar;
  logic [DEPTH_BITS-1:0] mar_d;
  logic [31:0]           mdr;
  logic [31:0]           mdr_d;
  logic [31:0]           wbuf;
  logic [31:0]           wbuf_d;
  logic                  op;
  logic                  op_d;
  logic                  busy_d;
  logic                  done_d;
  logic                  fault_d;
  logic                  read_d;
  logic                  write_d;
  logic                  in_range;

  assign in_range = (addr[31:DEPTH_BITS] == '0);

  // Every output is a flop loaded with the value its next state calls for, so
  // no input reaches an output combinationally.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    mar_d   = mar;
    mdr_d   = mdr;
    wbuf_d  = wbuf;
    op_d    = op;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    fault_d = 1'b0;
    read_d  = 1'b0;
    write_d = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          busy_d = 1'b1;
          op_d   = we;
          if (in_range) begin
            state_d = ACCESS;
            cnt_d   = CNT_LOAD;
            mar_d   = addr[DEPTH_BITS-1:0];
            mdr_d   = wdata;
            wbuf_d  = wdata;
            read_d  = ~we;
            write_d = we;
          end else begin
            // Fault leaves the memory-side address/data registers untouched.
            state_d = FAULT;
            mdr_d   = '0;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        busy_d = 1'b1;
        if (cnt == 4'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (!op) begin
            mdr_d = mem_data_out;
          end
        end else begin
          cnt_d   = cnt - 4'd1;
          read_d  = ~op;
          write_d = op;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      FAULT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mar       <= '0;
      mdr       <= '0;
      wbuf      <= '0;
      op        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      mar       <= mar_d;
      mdr       <= mdr_d;
      wbuf      <= wbuf_d;
      op        <= op_d;
      busy      <= busy_d;
      done      <= done_d;
      fault     <= fault_d;
      mem_read  <= read_d;
      mem_write <= write_d;
    end
  end

  assign rdata       = mdr;
  assign mem_address = {{(32-DEPTH_BITS){1'b0}}, mar};
  assign mem_data_in = wbuf;

endmodule

// File: tb/tb_mem_if.sv
// Scoreboard bench for mem_if: two instances (1 and 3 wait cycles), each with
// its own behavioural memory, checked against a word-array reference model.
module tb_mem_if;

  typedef struct {
    int          k;
    logic        we;
    logic        fault;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          acc;
    int          lat;
    int          strobes;
  } txn_t;

  logic        clock;
  logic        clear_n;
  logic        req_s     [2];
  logic        we_s      [2];
  logic [31:0] addr_s    [2];
  logic [31:0] wdata_s   [2];
  logic        busy_s    [2];
  logic        done_s    [2];
  logic        fault_s   [2];
  logic [31:0] rdata_s   [2];
  logic [31:0] ma_s      [2];
  logic [31:0] mdi_s     [2];
  logic        rd_s      [2];
  logic        wr_s      [2];
  logic [31:0] mdo_s     [2];

  logic [31:0] dev_mem   [2][512];
  logic [31:0] ref_mem   [2][512];
  logic [31:0] last_rdata[2];
  int          seen      [2];
  txn_t        exp_q[$];
  txn_t        cur;
  int          cyc;
  int          total;
  int          bad;

  mem_if #(.WAIT_CYCLES(1), .DEPTH_BITS(9)) u_w1 (
    .clock(clock), .clear_n(clear_n), .req(req_s[0]), .we(we_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .fault(fault_s[0]), .rdata(rdata_s[0]), .mem_address(ma_s[0]),
    .mem_data_in(mdi_s[0]), .mem_read(rd_s[0]), .mem_write(wr_s[0]),
    .mem_data_out(mdo_s[0])
  );

  mem_if #(.WAIT_CYCLES(3), .DEPTH_BITS(9)) u_w3 (
    .clock(clock), .clear_n(clear_n), .req(req_s[1]), .we(we_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .fault(fault_s[1]), .rdata(rdata_s[1]), .mem_address(ma_s[1]),
    .mem_data_in(mdi_s[1]), .mem_read(rd_s[1]), .mem_write(wr_s[1]),
    .mem_data_out(mdo_s[1])
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Combinational memory: read data only while the read strobe is high.
  assign mdo_s[0] = rd_s[0] ? dev_mem[0][ma_s[0][8:0]] : 32'd0;
  assign mdo_s[1] = rd_s[1] ? dev_mem[1][ma_s[1][8:0]] : 32'd0;

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (wr_s[k]) dev_mem[k][ma_s[k][8:0]] = mdi_s[k];
    end
  end

  function automatic int wc(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [127:0] outs(input int k);
    return 128'({busy_s[k], done_s[k], fault_s[k], rd_s[k], wr_s[k],
                 rdata_s[k], ma_s[k], mdi_s[k]});
  endfunction

  task automatic check(input string name, input int k,
                       input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h want=%0h", name, k, got, want);
    end
  endtask

  task automatic flag(input string name, input int k);
    total++;
    bad++;
    $display("FAIL %s dut%0d unexpected event", name, k);
  endtask

  // Reference: a word array; a store is visible to later loads, a fault
  // returns zero and touches nothing.
  task automatic push_exp(input int k, input logic w, input logic [31:0] a,
                          input logic [31:0] d);
    txn_t t;
    t.k       = k;
    t.we      = w;
    t.addr    = a;
    t.wdata   = d;
    t.acc     = cyc;
    t.fault   = (a >= 32'd512);
    t.lat     = t.fault ? 1 : wc(k) + 1;
    t.strobes = t.fault ? 0 : wc(k);
    if (t.fault) begin
      t.rdata = 32'd0;
    end else if (w) begin
      t.rdata = d;
      ref_mem[k][a[8:0]] = d;
    end else begin
      t.rdata = ref_mem[k][a[8:0]];
    end
    exp_q.push_back(t);
  endtask

  task automatic wait_idle(input int k, output bit ok);
    int n;
    n = 0;
    while ((busy_s[k] || exp_q.size() != 0) && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    ok = !(busy_s[k] || exp_q.size() != 0);
    if (!ok) flag("idle_timeout", k);
  endtask

  task automatic issue(input int k, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input bit poke);
    bit ok;
    wait_idle(k, ok);
    if (!ok) return;
    we_s[k] = w; addr_s[k] = a; wdata_s[k] = d; req_s[k] = 1'b1;
    @(posedge clock); #1;
    push_exp(k, w, a, d);
    // Scrambled fields and an optional stray req must not disturb the access.
    req_s[k]   = poke;
    we_s[k]    = 1'($urandom_range(0, 1));
    addr_s[k]  = $urandom;
    wdata_s[k] = $urandom;
    if (poke) begin
      @(posedge clock); #1;
      req_s[k] = 1'b0;
    end
  endtask

  task automatic back_to_back();
    bit ok;
    int n;
    logic [31:0] d1;
    logic [31:0] d2;
    wait_idle(0, ok);
    d1 = $urandom;
    d2 = $urandom;
    we_s[0] = 1'b0; addr_s[0] = 32'h2B; wdata_s[0] = d1; req_s[0] = 1'b1;
    @(posedge clock); #1;
    push_exp(0, 1'b0, 32'h2B, d1);
    addr_s[0] = 32'h33; wdata_s[0] = d2;
    n = 0;
    while (busy_s[0] && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    @(posedge clock); #1;
    push_exp(0, 1'b0, 32'h33, d2);
    req_s[0] = 1'b0;
    check("b2b_busy_gap", 0, 128'(busy_s[0]), 128'd1);
  endtask

  task automatic reset_mid_access();
    bit ok;
    logic [31:0] d;
    wait_idle(1, ok);
    d = $urandom;
    we_s[1] = 1'b1; addr_s[1] = 32'h1A0; wdata_s[1] = d; req_s[1] = 1'b1;
    @(posedge clock); #1;
    push_exp(1, 1'b1, 32'h1A0, d);
    req_s[1] = 1'b0;
    @(posedge clock); #1;
    clear_n = 1'b0;
    #1;
    check("reset_mid_access", 1, outs(1), 128'd0);
    check("reset_other", 0, outs(0), 128'd0);
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      seen[k] = 0;
      last_rdata[k] = 32'd0;
    end
    repeat (2) @(posedge clock);
    #1;
    clear_n = 1'b1;
    repeat (5) begin
      @(posedge clock); #1;
    end
    issue(1, 1'b0, 32'h1A0, $urandom, 1'b0);
  endtask

  always @(negedge clock) begin
    if (clear_n) begin
      for (int k = 0; k < 2; k++) begin
        check("strobe_excl", k, 128'(rd_s[k] & wr_s[k]), 128'd0);
        if (rd_s[k] || wr_s[k]) begin
          if (exp_q.size() == 0 || exp_q[0].k != k) begin
            flag("stray_strobe", k);
          end else begin
            check("strobe_kind", k, 128'(wr_s[k]), 128'(exp_q[0].we));
            check("mem_address", k, 128'(ma_s[k]), 128'({23'd0, exp_q[0].addr[8:0]}));
            check("mem_data_in", k, 128'(mdi_s[k]), 128'(exp_q[0].wdata));
            seen[k]++;
          end
        end
        if (done_s[k]) begin
          if (exp_q.size() == 0 || exp_q[0].k != k) begin
            flag("stray_done", k);
          end else begin
            cur = exp_q.pop_front();
            check("fault", k, 128'(fault_s[k]), 128'(cur.fault));
            check("rdata", k, 128'(rdata_s[k]), 128'(cur.rdata));
            check("latency", k, 128'(cyc - cur.acc + 1), 128'(cur.lat));
            check("strobe_cycles", k, 128'(seen[k]), 128'(cur.strobes));
            last_rdata[k] = cur.rdata;
          end
          seen[k] = 0;
        end
        if (!busy_s[k]) check("rdata_hold", k, 128'(rdata_s[k]), 128'(last_rdata[k]));
      end
    end
  end

  initial begin
    int n;
    clock   = 1'b0;
    clear_n = 1'b0;
    cyc     = 0;
    total   = 0;
    bad     = 0;
    for (int k = 0; k < 2; k++) begin
      req_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = 32'd0; wdata_s[k] = 32'd0;
      last_rdata[k] = 32'd0;
      seen[k] = 0;
      for (int i = 0; i < 512; i++) begin
        dev_mem[k][i] = $urandom;
        ref_mem[k][i] = dev_mem[k][i];
      end
    end
    dev_mem[0][9'h95] = 32'hD;
    ref_mem[0][9'h95] = 32'hD;

    repeat (3) @(posedge clock);
    #1;
    check("reset_state", 0, outs(0), 128'd0);
    check("reset_state", 1, outs(1), 128'd0);
    clear_n = 1'b1;
    @(posedge clock); #1;

    issue(0, 1'b0, 32'h95, $urandom, 1'b0);
    issue(1, 1'b1, 32'h87, 32'h43, 1'b0);
    issue(1, 1'b0, 32'h87, $urandom, 1'b0);
    issue(0, 1'b0, 32'h200, $urandom, 1'b0);
    issue(1, 1'b1, 32'h200, $urandom, 1'b1);
    issue(0, 1'b1, 32'hFFFF_FFFF, $urandom, 1'b0);
    issue(0, 1'b1, 32'h1FF, $urandom, 1'b1);
    back_to_back();
    issue(1, 1'b1, 32'h10, $urandom, 1'b1);
    issue(1, 1'b0, 32'h10, $urandom, 1'b0);
    reset_mid_access();

    for (int i = 0; i < 120; i++) begin
      int k;
      logic w;
      logic [31:0] a;
      k = i % 2;
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 511));
      issue(k, w, a, $urandom, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (exp_q.size() != 0) flag("drain_timeout", exp_q[0].k);
    repeat (3) @(posedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
